// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port.
// Requester 0 is the core (C), requester 1 is the boot loader / debug DMA (L).
// One access is outstanding at a time. Ties go round-robin against the last
// requester served. Each access waits for i_m_ready and gives up after
// TIMEOUT cycles, reporting o_err together with the done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  // core requester
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_done,
  output logic [DATA_W-1:0] o_c_rdata,
  // loader requester
  input  logic              i_l_req,
  input  logic              i_l_we,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_wdata,
  output logic              o_l_done,
  output logic [DATA_W-1:0] o_l_rdata,
  // memory side
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic              i_m_ready,
  // status
  output logic              o_err,
  output logic              o_owner
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // The counter only has to reach TIMEOUT-1; TIMEOUT >= 2 keeps CNT_W >= 1.
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             last_served;  // 0 = core, 1 = loader
  logic [CNT_W-1:0] wait_cnt;

  logic             grant_valid;
  logic             grant_sel;    // 0 = core, 1 = loader
  logic             access_end;   // ACCESS finishes this cycle (ready or timeout)

  // Pick the requester to grant from the current request levels.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    grant_valid = i_c_req | i_l_req;
    grant_sel   = 1'b0;
    if (i_c_req && i_l_req) begin
      grant_sel = ~last_served;
    end else if (i_l_req) begin
      grant_sel = 1'b1;
    end
  end

  assign access_end = (state == ACCESS) && (i_m_ready || (wait_cnt == CNT_LAST));

  // Sequence the IDLE -> ACCESS -> DONE handshake and the timeout counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    if (!i_rstn) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wait_cnt    <= '0;
      o_m_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state    <= ACCESS;
            wait_cnt <= '0;
            o_m_req  <= 1'b1;
          end
        end
        ACCESS: begin
          if (access_end) begin
            state   <= DONE;
            o_m_req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          last_served <= o_owner;
          state       <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_m_req <= 1'b0;
        end
      endcase
    end
  end

  // Latch the granted requester's command; it stays stable for the whole access.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_owner   <= 1'b0;
      o_m_we    <= 1'b0;
      o_m_addr  <= '0;
      o_m_wdata <= '0;
    end else if (state == IDLE && grant_valid) begin
      o_owner   <= grant_sel;
      o_m_we    <= grant_sel ? i_l_we    : i_c_we;
      o_m_addr  <= grant_sel ? i_l_addr  : i_c_addr;
      o_m_wdata <= grant_sel ? i_l_wdata : i_c_wdata;
    end
  end

  // Capture read data for the owner when memory completes a read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_c_rdata <= '0;
      o_l_rdata <= '0;
    end else if (state == ACCESS && i_m_ready && !o_m_we) begin
      if (o_owner) begin
        o_l_rdata <= i_m_rdata;
      end else begin
        o_c_rdata <= i_m_rdata;
      end
    end
  end

  // One-cycle done pulse to the owner, with err flagging a timeout.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_c_done <= 1'b0;
      o_l_done <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_c_done <= access_end && !o_owner;
      o_l_done <= access_end &&  o_owner;
      o_err    <= access_end && !i_m_ready;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory latency, all compared
// every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              i_clk;
  logic              i_rstn;
  logic              i_c_req, i_c_we;
  logic [ADDR_W-1:0] i_c_addr;
  logic [DATA_W-1:0] i_c_wdata;
  logic              o_c_done;
  logic [DATA_W-1:0] o_c_rdata;
  logic              i_l_req, i_l_we;
  logic [ADDR_W-1:0] i_l_addr;
  logic [DATA_W-1:0] i_l_wdata;
  logic              o_l_done;
  logic [DATA_W-1:0] o_l_rdata;
  logic              o_m_req, o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_wdata;
  logic [DATA_W-1:0] i_m_rdata;
  logic              i_m_ready;
  logic              o_err, o_owner;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_c_req(i_c_req), .i_c_we(i_c_we), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
    .o_c_done(o_c_done), .o_c_rdata(o_c_rdata),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_done(o_l_done), .o_l_rdata(o_l_rdata),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .i_m_rdata(i_m_rdata), .i_m_ready(i_m_ready),
    .o_err(o_err), .o_owner(o_owner)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                owner;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t              cur;
  int                age;      // cycles the current access has been on the bus, 0 = none
  bit                closing;  // the cycle carrying the done pulse
  bit                last;     // last requester served

  logic              e_m_req, e_m_we, e_c_done, e_l_done, e_err, e_owner;
  logic [ADDR_W-1:0] e_m_addr;
  logic [DATA_W-1:0] e_m_wdata, e_c_rdata, e_l_rdata;

  task automatic model_reset();
    age = 0; closing = 0; last = 1'b1;
    e_m_req = 0; e_m_we = 0; e_c_done = 0; e_l_done = 0; e_err = 0; e_owner = 0;
    e_m_addr = '0; e_m_wdata = '0; e_c_rdata = '0; e_l_rdata = '0;
  endtask

  // Advance the model across one clock edge using the inputs seen before it.
  task automatic model_step();
    e_c_done = 0; e_l_done = 0; e_err = 0;
    if (closing) begin
      closing = 0;
      last    = cur.owner;
    end else if (age > 0) begin
      if (i_m_ready || age == TIMEOUT) begin
        e_m_req = 0;
        closing = 1;
        age     = 0;
        e_err   = !i_m_ready;
        if (cur.owner) e_l_done = 1; else e_c_done = 1;
        if (i_m_ready && !cur.we) begin
          if (cur.owner) e_l_rdata = i_m_rdata; else e_c_rdata = i_m_rdata;
        end
      end else begin
        age++;
      end
    end else if (i_c_req || i_l_req) begin
      cur.owner = (i_c_req && i_l_req) ? !last : i_l_req;
      cur.we    = cur.owner ? i_l_we    : i_c_we;
      cur.addr  = cur.owner ? i_l_addr  : i_c_addr;
      cur.wdata = cur.owner ? i_l_wdata : i_c_wdata;
      age       = 1;
      e_m_req   = 1;
      e_m_we    = cur.we;
      e_m_addr  = cur.addr;
      e_m_wdata = cur.wdata;
      e_owner   = cur.owner;
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge i_clk) begin
    if (!i_rstn) model_reset();
    check("m_req",   o_m_req,   e_m_req);
    check("m_we",    o_m_we,    e_m_we);
    check("m_addr",  o_m_addr,  e_m_addr);
    check("m_wdata", o_m_wdata, e_m_wdata);
    check("c_done",  o_c_done,  e_c_done);
    check("l_done",  o_l_done,  e_l_done);
    check("c_rdata", o_c_rdata, e_c_rdata);
    check("l_rdata", o_l_rdata, e_l_rdata);
    check("err",     o_err,     e_err);
    check("owner",   o_owner,   e_owner);
    check("one_done", {o_c_done, o_l_done} == 2'b11, 1'b0);
    if (i_rstn) model_step();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    i_c_req = 0; i_c_we = 0; i_c_addr = '0; i_c_wdata = '0;
    i_l_req = 0; i_l_we = 0; i_l_addr = '0; i_l_wdata = '0;
    i_m_ready = 0; i_m_rdata = '0;
  endtask

  // Reset for two cycles; returns at the start of a clean IDLE cycle 0.
  task automatic do_reset();
    i_rstn = 0;
    clear_inputs();
    repeat (2) next_cycle();
    i_rstn = 1;
    next_cycle();
  endtask

  bit cd, ld;
  int ready_pct;

  initial begin
    i_rstn = 0;
    clear_inputs();
    next_cycle();
    do_reset();

    // Core read at 0x100, ready in cycle 1.
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 0) begin i_c_req = 1; i_c_we = 0; i_c_addr = 32'h100; end
      if (cyc == 1) begin i_m_ready = 1; i_m_rdata = 32'hDEADBEEF; end
      if (cyc == 2) begin i_m_ready = 0; i_c_req = 0; end
      to_sample();
      check("t1_m_req", o_m_req, cyc == 1);
      if (cyc == 1) begin
        check("t1_m_addr", o_m_addr, 32'h100);
        check("t1_m_we", o_m_we, 1'b0);
      end
      check("t1_c_done", o_c_done, cyc == 2);
      if (cyc == 2) begin
        check("t1_c_rdata", o_c_rdata, 32'hDEADBEEF);
        check("t1_err", o_err, 1'b0);
      end
      next_cycle();
    end

    // Loader write at 0x40, ready delayed to cycle 5.
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 0) begin i_l_req = 1; i_l_we = 1; i_l_addr = 32'h40; i_l_wdata = 32'h1234; end
      if (cyc == 5) begin i_m_ready = 1; i_m_rdata = 32'hCAFEF00D; end
      if (cyc == 6) begin i_m_ready = 0; i_l_req = 0; end
      to_sample();
      check("t3_m_req", o_m_req, cyc >= 1 && cyc <= 5);
      if (cyc >= 1 && cyc <= 5) begin
        check("t3_m_we", o_m_we, 1'b1);
        check("t3_m_wdata", o_m_wdata, 32'h1234);
        check("t3_owner", o_owner, 1'b1);
      end
      check("t3_l_done", o_l_done, cyc == 6);
      if (cyc == 6) check("t3_l_rdata", o_l_rdata, 32'h0);
      next_cycle();
    end

    // Both requesters right after reset with memory always ready: C, L, C, L.
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 0) begin
        i_c_req = 1; i_c_we = 0; i_c_addr = 32'h200;
        i_l_req = 1; i_l_we = 0; i_l_addr = 32'h300;
        i_m_ready = 1; i_m_rdata = 32'h55AA_0001;
      end
      to_sample();
      if (cyc % 3 == 1) begin
        check("t2_m_req", o_m_req, 1'b1);
        check("t2_owner", o_owner, (cyc / 3) % 2);
      end
      if (cyc == 2) check("t2_c_done", o_c_done, 1'b1);
      if (cyc == 5) check("t2_l_done", o_l_done, 1'b1);
      next_cycle();
    end
    i_c_req = 0; i_l_req = 0; i_m_ready = 0;
    repeat (2) next_cycle();

    // Core read that never gets ready, then a normal access.
    for (int cyc = 0; cyc < 21; cyc++) begin
      if (cyc == 0) begin i_c_req = 1; i_c_we = 0; i_c_addr = 32'h500; end
      if (cyc == 18) begin i_m_ready = 1; i_m_rdata = 32'h0BAD_F00D; end
      if (cyc == 19) begin i_m_ready = 0; i_c_req = 0; end
      to_sample();
      if (cyc >= 1 && cyc <= 15) check("t4_m_req_hold", o_m_req, 1'b1);
      if (cyc == 16) begin
        check("t4_timeout_done", o_c_done, 1'b1);
        check("t4_timeout_err", o_err, 1'b1);
        check("t4_m_req_drop", o_m_req, 1'b0);
        check("t4_rdata_kept", o_c_rdata, 32'h55AA_0001);
      end
      if (cyc == 18) check("t4_retry_m_req", o_m_req, 1'b1);
      if (cyc == 19) begin
        check("t4_retry_done", o_c_done, 1'b1);
        check("t4_retry_err", o_err, 1'b0);
      end
      next_cycle();
    end

    // Reset asserted in cycle 3 of a loader access with ready pending.
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 0) begin i_l_req = 1; i_l_we = 0; i_l_addr = 32'h80; end
      if (cyc == 3) begin
        #2 i_rstn = 0;
        #1;
        check("t5_rst_m_req", o_m_req, 1'b0);
        check("t5_rst_owner", o_owner, 1'b0);
        check("t5_rst_l_done", o_l_done, 1'b0);
        check("t5_rst_m_addr", o_m_addr, 32'h0);
        check("t5_rst_c_rdata", o_c_rdata, 32'h0);
        i_l_req = 0;
      end
      to_sample();
      next_cycle();
    end
    next_cycle();
    i_rstn = 1;
    next_cycle();
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 0) begin
        i_c_req = 1; i_c_addr = 32'hC0;
        i_l_req = 1; i_l_addr = 32'hD0;
        i_m_ready = 1; i_m_rdata = 32'h1111_2222;
      end
      if (cyc == 3) i_c_req = 0;
      if (cyc == 6) begin i_l_req = 0; i_m_ready = 0; end
      to_sample();
      if (cyc == 1) begin
        check("t5_first_owner", o_owner, 1'b0);
        check("t5_first_addr", o_m_addr, 32'hC0);
      end
      if (cyc == 2) check("t5_first_done", o_c_done, 1'b1);
      next_cycle();
    end

    // Ready pulsed while idle with no requests.
    for (int cyc = 0; cyc < 3; cyc++) begin
      i_m_ready = (cyc == 0);
      to_sample();
      check("t6_m_req", o_m_req, 1'b0);
      check("t6_c_done", o_c_done, 1'b0);
      check("t6_l_done", o_l_done, 1'b0);
      next_cycle();
    end

    // Randomized requesters and memory latency.
    ready_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      to_sample();
      cd = o_c_done;
      ld = o_l_done;
      next_cycle();
      if (n % 400 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_pct = 70;
          1:       ready_pct = 20;
          default: ready_pct = 0;
        endcase
      end
      if (!i_c_req || cd) begin
        i_c_req   = ($urandom_range(0, 3) != 0);
        i_c_we    = $urandom_range(0, 1);
        i_c_addr  = $urandom;
        i_c_wdata = $urandom;
      end
      if (!i_l_req || ld) begin
        i_l_req   = ($urandom_range(0, 3) != 0);
        i_l_we    = $urandom_range(0, 1);
        i_l_addr  = $urandom;
        i_l_wdata = $urandom;
      end
      i_m_ready = ($urandom_range(0, 99) < ready_pct);
      i_m_rdata = $urandom;
    end

    to_sample();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
